// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts MEM-stage requests, inserts WAIT_CYCLES wait states, pulses Mem_Ready.
// Optional macro DMEM_ACCESS_COUNT_EN adds legal read/write access counters.
//
// state  | meaning
// S_IDLE | no access in flight, a request is accepted on the next edge
// S_WAIT | wait states counting down on the latched request
// S_DONE | Mem_Ready pulse, write committed and read data loaded on entry
module data_memory_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic [31:0] Memory_Address,
  input  logic [31:0] Write_Data_Memory,
  output logic [31:0] Read_Data_Memory,
  output logic        Mem_Ready,
  output logic        Mem_Stall,
  output logic        Addr_Error
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] Read_Count,
  output logic [31:0] Write_Count
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic          r_rd, r_wr, r_illegal;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req, w_accept, w_illegal_in, w_enter_done;
  logic          w_cur_rd, w_cur_wr, w_cur_illegal, w_commit_wr, w_commit_rd;
  logic [AW-1:0] w_cur_idx;
  logic [31:0]   w_cur_wdata;

  assign w_req        = Mem_Read | Mem_Write;
  assign w_accept     = (r_state == S_IDLE) & w_req;
  assign w_illegal_in = (Memory_Address[1:0] != 2'b00) | (|Memory_Address[31:AW+2])
                      | (Mem_Read & Mem_Write);

  // With zero wait states DONE is entered on the acceptance edge, before the latches hold the request.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_cur_idx     = Memory_Address[AW+1:2];
      w_cur_wdata   = Write_Data_Memory;
      w_cur_rd      = Mem_Read;
      w_cur_wr      = Mem_Write;
      w_cur_illegal = w_illegal_in;
    end else begin
      w_cur_idx     = r_idx;
      w_cur_wdata   = r_wdata;
      w_cur_rd      = r_rd;
      w_cur_wr      = r_wr;
      w_cur_illegal = r_illegal;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_done = (w_state_nxt == S_DONE);
  assign w_commit_wr  = w_enter_done & w_cur_wr & ~w_cur_illegal & ~rst;
  assign w_commit_rd  = w_enter_done & w_cur_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= 4'd0;
      r_idx            <= '0;
      r_wdata          <= 32'd0;
      r_rd             <= 1'b0;
      r_wr             <= 1'b0;
      r_illegal        <= 1'b0;
      Read_Data_Memory <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx     <= Memory_Address[AW+1:2];
        r_wdata   <= Write_Data_Memory;
        r_rd      <= Mem_Read;
        r_wr      <= Mem_Write;
        r_illegal <= w_illegal_in;
      end
      if (w_commit_rd) Read_Data_Memory <= w_cur_illegal ? 32'd0 : r_mem[w_cur_idx];
    end
  end

  // Array contents survive reset; only an in-flight write is dropped.
  always_ff @(posedge clk) begin
    if (w_commit_wr) r_mem[w_cur_idx] <= w_cur_wdata;
  end

  assign Mem_Ready  = (r_state == S_DONE);
  assign Addr_Error = Mem_Ready & r_illegal;
  assign Mem_Stall  = w_req & ~Mem_Ready;

`ifdef DMEM_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Read_Count  <= 32'd0;
      Write_Count <= 32'd0;
    end else begin
      if (w_commit_rd & ~w_cur_illegal) Read_Count  <= Read_Count + 32'd1;
      if (w_commit_wr)                  Write_Count <= Write_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: one instance with 2 wait states, one with none.
// Counter checks are compiled in when DMEM_ACCESS_COUNT_EN is defined.
module tb_data_memory_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        req_rd, req_wr, rdy, stall, err;
  logic [1:0][31:0]  req_addr, req_wdata, rdata;
`ifdef DMEM_ACCESS_COUNT_EN
  logic [1:0][31:0]  rcnt, wcnt;
`endif

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst),
    .Mem_Read(req_rd[0]), .Mem_Write(req_wr[0]),
    .Memory_Address(req_addr[0]), .Write_Data_Memory(req_wdata[0]),
    .Read_Data_Memory(rdata[0]), .Mem_Ready(rdy[0]),
    .Mem_Stall(stall[0]), .Addr_Error(err[0])
`ifdef DMEM_ACCESS_COUNT_EN
    , .Read_Count(rcnt[0]), .Write_Count(wcnt[0])
`endif
  );

  data_memory_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .Mem_Read(req_rd[1]), .Mem_Write(req_wr[1]),
    .Memory_Address(req_addr[1]), .Write_Data_Memory(req_wdata[1]),
    .Read_Data_Memory(rdata[1]), .Mem_Ready(rdy[1]),
    .Mem_Stall(stall[1]), .Addr_Error(err[1])
`ifdef DMEM_ACCESS_COUNT_EN
    , .Read_Count(rcnt[1]), .Write_Count(wcnt[1])
`endif
  );

  typedef struct {
    string       tag;
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          chk_rd;
  } exp_t;

  exp_t        sb_q [$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_mem  [2][256];
  logic [31:0] m_last [2];
  int          exp_rc = 0;
  int          exp_wc = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; leaves at the negedge after the Mem_Ready cycle with requests dropped.
  task automatic access(input int sel, input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d, input bit chk_rd);
    exp_t e;
    bit   legal;
    int   n;
    bit   got;
    int   lat;
    legal = (a[1:0] == 2'b00) && (a < 32'd1024) && !(rd && wr);
    if (wr && legal) m_mem[sel][a[9:2]] = d;
    if (rd) m_last[sel] = legal ? m_mem[sel][a[9:2]] : 32'd0;
    if (sel == 0 && legal && rd) exp_rc++;
    if (sel == 0 && legal && wr) exp_wc++;
    e.tag = tag; e.exp_rd = m_last[sel]; e.exp_err = !legal; e.chk_rd = chk_rd;
    sb_q.push_back(e);
    lat = (sel == 0) ? 3 : 1;
    req_rd[sel] = rd; req_wr[sel] = wr; req_addr[sel] = a; req_wdata[sel] = d;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (rdy[sel]) got = 1;
      else check_eq({tag, "_stall"}, 32'(stall[sel]), 32'd1);
    end
    e = sb_q.pop_front();
    if (!got) begin
      check_eq({e.tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({e.tag, "_lat"}, 32'(n), 32'(lat));
      check_eq({e.tag, "_stall_rdy"}, 32'(stall[sel]), 32'd0);
      check_eq({e.tag, "_err"}, 32'(err[sel]), 32'(e.exp_err));
      if (e.chk_rd) check_eq({e.tag, "_rdata"}, rdata[sel], e.exp_rd);
    end
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(rdy[sel]), 32'd0);
    req_rd[sel] = 1'b0; req_wr[sel] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int s = 0; s < 2; s++) begin
      check_eq({tag, "_rdy"},   32'(rdy[s]),   32'd0);
      check_eq({tag, "_err"},   32'(err[s]),   32'd0);
      check_eq({tag, "_rdata"}, rdata[s],      32'd0);
      check_eq({tag, "_stall"}, 32'(stall[s]), 32'd0);
`ifdef DMEM_ACCESS_COUNT_EN
      check_eq({tag, "_rcnt"}, rcnt[s], 32'd0);
      check_eq({tag, "_wcnt"}, wcnt[s], 32'd0);
`endif
    end
    m_last[0] = 32'd0; m_last[1] = 32'd0;
    exp_rc = 0; exp_wc = 0;
  endtask

  initial begin
    logic [31:0] addr_tab [6];
    addr_tab[0] = 32'h000; addr_tab[1] = 32'h010; addr_tab[2] = 32'h020;
    addr_tab[3] = 32'h030; addr_tab[4] = 32'h040; addr_tab[5] = 32'h044;
    req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    m_last[0] = 32'd0; m_last[1] = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    access(0, "wr_10",  0, 1, 32'h010, 32'hDEADBEEF, 1);
    access(0, "rd_10",  1, 0, 32'h010, 32'h0, 1);
    access(0, "wr_00",  0, 1, 32'h000, 32'h12345678, 1);
    access(0, "rd_mis", 1, 0, 32'h012, 32'h0, 1);
    access(0, "wr_oor", 0, 1, 32'h400, 32'hFFFFFFFF, 1);
    access(0, "rd_00",  1, 0, 32'h000, 32'h0, 1);
    access(0, "wr_20",  0, 1, 32'h020, 32'h11111111, 1);
    access(0, "both",   1, 1, 32'h020, 32'h22222222, 0);
    access(0, "rd_20",  1, 0, 32'h020, 32'h0, 1);
    access(0, "wr_30",  0, 1, 32'h030, 32'h0BADC0DE, 1);

    access(1, "z_wr",   0, 1, 32'h008, 32'h13579BDF, 1);
    access(1, "z_rd1",  1, 0, 32'h008, 32'h0, 1);
    access(1, "z_rd2",  1, 0, 32'h008, 32'h0, 1);
    access(1, "z_mis",  1, 0, 32'h009, 32'h0, 1);

    // Abort a write in the wait-state phase.
    req_wr[0] = 1'b1; req_addr[0] = 32'h030; req_wdata[0] = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b1; req_wr[0] = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("abort_no_rdy", 32'(rdy[0]), 32'd0);
    end

    access(0, "rd_30",  1, 0, 32'h030, 32'h0, 1);
    access(0, "wr_40",  0, 1, 32'h040, 32'hAAAA5555, 1);
    access(0, "wr_44",  0, 1, 32'h044, 32'h5555AAAA, 1);
    access(0, "rd_40",  1, 0, 32'h040, 32'h0, 1);
    access(0, "rd_44",  1, 0, 32'h044, 32'h0, 1);
    access(0, "rd_41",  1, 0, 32'h041, 32'h0, 1);
`ifdef DMEM_ACCESS_COUNT_EN
    check_eq("cnt_rd", rcnt[0], 32'd3);
    check_eq("cnt_wr", wcnt[0], 32'd2);
`endif

    for (int i = 0; i < 10; i++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = addr_tab[$urandom_range(0, 5)];
      case (op)
        0:       access(0, "rnd_rd",  1, 0, a, 32'h0, 1);
        1:       access(0, "rnd_wr",  0, 1, a, $urandom, 1);
        default: access(0, "rnd_mis", 1, 0, a | 32'h2, 32'h0, 1);
      endcase
    end
`ifdef DMEM_ACCESS_COUNT_EN
    check_eq("cnt_rd_rnd", rcnt[0], 32'(exp_rc));
    check_eq("cnt_wr_rnd", wcnt[0], 32'(exp_wc));
`endif

    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("final_rst");
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Memory-side responder for the pipeline's data-memory access path.
- Accepts the single-cycle read/write requests issued by the MEM stage (Mem_Read, Mem_Write, address, write data).
- Services each request after a configurable number of wait states and returns a one-cycle Mem_Ready pulse with registered read data.
- Drives a combinational Mem_Stall so the hazard logic can freeze PC, IF/ID, ID/EX, EX/M and M/WB while an access is in flight.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored; power of two, 4..65536.
- WAIT_CYCLES, 2: wait-state cycles between request acceptance and the Mem_Ready pulse; 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Mem_Read  input  1  read request, level; held by the initiator until Mem_Ready.
- Mem_Write  input  1  write request, level; held by the initiator until Mem_Ready.
- Memory_Address  input  32  byte address.
- Write_Data_Memory  input  32  store data.
- Read_Data_Memory  output  32  registered load data.
- Mem_Ready  output  1  one-cycle completion pulse.
- Mem_Stall  output  1  combinational: (Mem_Read|Mem_Write) & ~Mem_Ready.
- Addr_Error  output  1  one-cycle pulse, coincident with Mem_Ready, on an illegal access.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, wait counter=0, Read_Data_Memory=0, Mem_Ready=0, Addr_Error=0.
  - The memory array is not cleared by reset.
  - Reset mid-access aborts the access. A pending write is dropped and no Mem_Ready is issued.
- State machine has three states: IDLE, WAIT, DONE.
- IDLE:
  - On an edge where Mem_Read|Mem_Write=1, latch address, data, op and legality.
  - Go to WAIT with counter=WAIT_CYCLES-1, or go directly to DONE if WAIT_CYCLES=0.
- WAIT: the counter decrements each cycle. At 0 go to DONE.
- DONE:
  - Mem_Ready=1 for exactly this cycle; Addr_Error=1 in this cycle if the access was illegal.
  - Next state is always IDLE.
  - A request still asserted during DONE is not accepted. The initiator drops its request in the cycle following Mem_Ready.
- Latency: Mem_Ready is high WAIT_CYCLES+1 cycles after the acceptance edge. Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- Inputs are ignored in WAIT and DONE; only latched values are used.
- Word index = address[log2(DEPTH_WORDS)+1:2].
- Illegal accesses:
  - Address[1:0]!=0 (misaligned).
  - Address >= 4*DEPTH_WORDS (out of range).
  - Mem_Read and Mem_Write both high.
  - An illegal write does not modify memory. An illegal read loads Read_Data_Memory=0.
- Write commit: the array is written on the edge that enters DONE.
- Read_Data_Memory:
  - Loaded on the edge entering DONE for reads.
  - Unchanged by writes.
  - Holds its value until the next read completes.
- Read-after-write to the same word in consecutive accesses returns the new data.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- Defined:
  - Adds outputs Read_Count[31:0] and Write_Count[31:0], both reset to 0.
  - Each counter increments on the edge entering DONE for a legal read or legal write respectively.
  - Counters wrap from 0xFFFFFFFF to 0.
  - Illegal accesses increment neither counter.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then WAIT_CYCLES=2: write 0xDEADBEEF to 0x10 (request accepted at edge T) -> Mem_Stall=1 until Mem_Ready=1 at T+3 for one cycle. A following read of 0x10 returns 0xDEADBEEF with Addr_Error=0.
- WAIT_CYCLES=0: read request -> Mem_Ready exactly 1 cycle after acceptance. Back-to-back requests are accepted every 2 cycles.
- Misaligned read at 0x12 and out-of-range write at 0x400 (DEPTH_WORDS=256) -> Addr_Error=1 with Mem_Ready. Read data=0; word 0 (0x000) is unchanged afterwards.
- Mem_Read=Mem_Write=1 to 0x20 holding 0x11111111, write data 0x22222222 -> Addr_Error=1. A later read of 0x20 returns 0x11111111.
- rst asserted in WAIT during a write of 0xCAFEF00D to 0x30 -> no Mem_Ready, all outputs 0 next cycle. A later read of 0x30 returns the old value.
- With DMEM_ACCESS_COUNT_EN: 3 legal reads, 2 legal writes, 1 misaligned read -> Read_Count=3, Write_Count=2. After rst both read 0.
